// File: rtl/unified_mem_arbiter.sv
// Arbitrates IF and LS requesters onto one single-port sync-read memory; LS has priority with a starvation escape for IF.
// Latency: 1 cycle accept-to-response, 1 request/cycle; no response backpressure, requesters stall via req_ready.
module unified_mem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_DEPTH    = 'h4000,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         if_req_valid,
  output logic                         if_req_ready,
  input  logic [ADDR_WIDTH-1:0]        if_req_addr,
  output logic                         if_rsp_valid,
  output logic [DATA_WIDTH-1:0]        if_rsp_data,
  output logic                         if_rsp_err,
  input  logic                         ls_req_valid,
  output logic                         ls_req_ready,
  input  logic [ADDR_WIDTH-1:0]        ls_req_addr,
  input  logic                         ls_req_we,
  input  logic [DATA_WIDTH/8-1:0]      ls_req_be,
  input  logic [DATA_WIDTH-1:0]        ls_req_wdata,
  output logic                         ls_rsp_valid,
  output logic [DATA_WIDTH-1:0]        ls_rsp_data,
  output logic                         ls_rsp_err,
  output logic                         mem_en,
  output logic [DATA_WIDTH/8-1:0]      mem_we,
  output logic [$clog2(MEM_DEPTH)-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]        mem_wdata,
  input  logic [DATA_WIDTH-1:0]        mem_rdata
);

  localparam int          BE_W       = DATA_WIDTH / 8;
  localparam int          IDX_W      = $clog2(MEM_DEPTH);
  localparam int          CNT_W      = $clog2(STARVE_LIMIT + 1);
  localparam logic [63:0] BYTE_LIMIT = 64'(MEM_DEPTH) * 64'd4;

  logic [CNT_W-1:0]      starve_cnt_q, starve_cnt_d;
  logic                  rsp_vld_q, rsp_vld_d;
  logic                  rsp_ls_q, rsp_ls_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_rd_q, rsp_rd_d;

  logic                  starve_hit;
  logic                  if_gnt;
  logic                  ls_gnt;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  sel_oor;
  logic [DATA_WIDTH-1:0] rsp_word;

  // Grants are suppressed while rst is high so nothing is accepted or written.
  always_comb begin
    starve_hit = if_req_valid && (starve_cnt_q == CNT_W'(STARVE_LIMIT));
    if_gnt     = !rst && if_req_valid && (starve_hit || !ls_req_valid);
    ls_gnt     = !rst && ls_req_valid && !starve_hit;
    sel_addr   = ls_gnt ? ls_req_addr : if_req_addr;
    sel_oor    = 64'(sel_addr) >= BYTE_LIMIT;

    if_req_ready = if_gnt;
    ls_req_ready = ls_gnt;
    mem_en       = (if_gnt || ls_gnt) && !sel_oor;
    mem_we       = (mem_en && ls_gnt && ls_req_we) ? ls_req_be : '0;
    mem_addr     = sel_addr[2 +: IDX_W];
    mem_wdata    = ls_gnt ? ls_req_wdata : '0;
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!if_req_valid || if_gnt) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != CNT_W'(STARVE_LIMIT)) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end

    rsp_vld_d = if_gnt || ls_gnt;
    rsp_ls_d  = ls_gnt;
    rsp_err_d = sel_oor;
    rsp_rd_d  = !(ls_gnt && ls_req_we);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= '0;
      rsp_vld_q    <= 1'b0;
      rsp_ls_q     <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_rd_q     <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rsp_vld_q    <= rsp_vld_d;
      rsp_ls_q     <= rsp_ls_d;
      rsp_err_q    <= rsp_err_d;
      rsp_rd_q     <= rsp_rd_d;
    end
  end

  // Responses are masked during rst so an in-flight access never surfaces.
  always_comb begin
    rsp_word     = (rsp_rd_q && !rsp_err_q) ? mem_rdata : '0;
    if_rsp_valid = !rst && rsp_vld_q && !rsp_ls_q;
    ls_rsp_valid = !rst && rsp_vld_q && rsp_ls_q;
    if_rsp_data  = if_rsp_valid ? rsp_word : '0;
    ls_rsp_data  = ls_rsp_valid ? rsp_word : '0;
    if_rsp_err   = if_rsp_valid && rsp_err_q;
    ls_rsp_err   = ls_rsp_valid && rsp_err_q;
  end

  logic unused_be_w;
  assign unused_be_w = (BE_W == 0);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter with a behavioural sync-read memory.
module tb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req_valid = 1'b0;
  logic        if_req_ready;
  logic [31:0] if_req_addr = '0;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_data;
  logic        if_rsp_err;
  logic        ls_req_valid = 1'b0;
  logic        ls_req_ready;
  logic [31:0] ls_req_addr = '0;
  logic        ls_req_we = 1'b0;
  logic [3:0]  ls_req_be = '0;
  logic [31:0] ls_req_wdata = '0;
  logic        ls_rsp_valid;
  logic [31:0] ls_rsp_data;
  logic        ls_rsp_err;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:16383];
  logic        pl_en = 1'b0;
  logic [13:0] pl_addr = '0;
  logic [31:0] pl_dat = '0;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  unified_mem_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH('h4000), .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data), .if_rsp_err(if_rsp_err),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_addr(ls_req_addr),
    .ls_req_we(ls_req_we), .ls_req_be(ls_req_be), .ls_req_wdata(ls_req_wdata),
    .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data), .ls_rsp_err(ls_rsp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_addr] <= pl_dat;
    end else if (mem_en) begin
      mem_rdata <= mem[mem_addr];
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  task automatic preload(input logic [13:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_dat = d;
  endtask

  task automatic test_reset();
    @(negedge clk);
    pl_en = 1'b0;
    if_req_valid = 1'b1; if_req_addr = 32'h0;
    ls_req_valid = 1'b1; ls_req_addr = 32'h4; ls_req_we = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_assert++; if (if_req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_if_ready c%0d got %b want 0", c, if_req_ready); end
      n_assert++; if (ls_req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ls_ready c%0d got %b want 0", c, ls_req_ready); end
      n_assert++; if (mem_en !== 1'b0 || mem_we !== 4'h0) begin n_fail++; $display("FAIL rst_mem c%0d got en=%b we=%h want 0", c, mem_en, mem_we); end
      n_assert++; if ({if_rsp_valid, ls_rsp_valid, if_rsp_err, ls_rsp_err} !== 4'b0 || if_rsp_data !== 32'h0 || ls_rsp_data !== 32'h0) begin
        n_fail++; $display("FAIL rst_rsp c%0d got vld=%b%b data=%h/%h want 0", c, if_rsp_valid, ls_rsp_valid, if_rsp_data, ls_rsp_data);
      end
      @(negedge clk);
    end
    rst = 1'b0;
    #1;
    n_assert++; if (ls_req_ready !== 1'b1 || if_req_ready !== 1'b0) begin n_fail++; $display("FAIL first_accept got ls=%b if=%b want ls=1 if=0", ls_req_ready, if_req_ready); end
    n_assert++; if (mem_en !== 1'b1 || mem_addr !== 14'd1) begin n_fail++; $display("FAIL first_mem got en=%b addr=%h want en=1 addr=1", mem_en, mem_addr); end
    @(negedge clk);
    if_req_valid = 1'b0; ls_req_valid = 1'b0;
    #1;
    n_assert++; if (ls_rsp_valid !== 1'b1 || ls_rsp_data !== 32'h93 || if_rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL first_rsp got ls_vld=%b data=%h if_vld=%b want 1 93 0", ls_rsp_valid, ls_rsp_data, if_rsp_valid);
    end
  endtask

  task automatic test_if_only();
    logic [31:0] exp_d [0:2];
    exp_d[0] = 32'h13; exp_d[1] = 32'h93; exp_d[2] = 32'h113;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if_req_valid = (k < 3);
      if_req_addr  = 32'(4 * k);
      #1;
      if (k < 3) begin
        n_assert++; if (if_req_ready !== 1'b1 || mem_addr !== 14'(k)) begin n_fail++; $display("FAIL if_accept k%0d got rdy=%b addr=%h want 1 %h", k, if_req_ready, mem_addr, k); end
      end
      if (k == 0) begin
        n_assert++; if (if_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL if_rsp_idle got %b want 0", if_rsp_valid); end
      end else begin
        n_assert++; if (if_rsp_valid !== 1'b1 || if_rsp_data !== exp_d[k-1] || if_rsp_err !== 1'b0) begin
          n_fail++; $display("FAIL if_rsp k%0d got vld=%b data=%h err=%b want 1 %h 0", k, if_rsp_valid, if_rsp_data, if_rsp_err, exp_d[k-1]);
        end
      end
    end
  endtask

  task automatic test_store_load();
    @(negedge clk);
    ls_req_valid = 1'b1; ls_req_addr = 32'h100; ls_req_we = 1'b1;
    ls_req_be = 4'b0011; ls_req_wdata = 32'hAABBCCDD;
    #1;
    n_assert++; if (ls_req_ready !== 1'b1 || mem_we !== 4'b0011 || mem_addr !== 14'h40 || mem_wdata !== 32'hAABBCCDD) begin
      n_fail++; $display("FAIL store_drive got rdy=%b we=%h addr=%h wd=%h want 1 3 40 aabbccdd", ls_req_ready, mem_we, mem_addr, mem_wdata);
    end
    @(negedge clk);
    ls_req_we = 1'b0; ls_req_be = 4'h0;
    #1;
    n_assert++; if (mem_we !== 4'h0) begin n_fail++; $display("FAIL load_we got %h want 0", mem_we); end
    n_assert++; if (ls_rsp_valid !== 1'b1 || ls_rsp_data !== 32'h0) begin n_fail++; $display("FAIL store_ack got vld=%b data=%h want 1 0", ls_rsp_valid, ls_rsp_data); end
    @(negedge clk);
    ls_req_valid = 1'b0;
    #1;
    n_assert++; if (ls_rsp_valid !== 1'b1 || ls_rsp_data !== 32'h1122CCDD) begin n_fail++; $display("FAIL load_merge got vld=%b data=%h want 1 1122ccdd", ls_rsp_valid, ls_rsp_data); end
  endtask

  task automatic test_starvation();
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      if_req_valid = 1'b1; if_req_addr = 32'h0;
      ls_req_valid = 1'b1; ls_req_addr = 32'h100; ls_req_we = 1'b0;
      #1;
      n_assert++; if (ls_req_ready !== (i % 5 != 4) || if_req_ready !== (i % 5 == 4)) begin
        n_fail++; $display("FAIL starve_grant i%0d got ls=%b if=%b want ls=%b if=%b", i, ls_req_ready, if_req_ready, (i % 5 != 4), (i % 5 == 4));
      end
      if (i > 0) begin
        n_assert++; if (if_rsp_valid !== ((i - 1) % 5 == 4) || ls_rsp_valid !== ((i - 1) % 5 != 4)) begin
          n_fail++; $display("FAIL starve_rsp i%0d got if=%b ls=%b", i, if_rsp_valid, ls_rsp_valid);
        end
      end
      if (i == 5) begin
        n_assert++; if (if_rsp_data !== 32'h13) begin n_fail++; $display("FAIL starve_if_data got %h want 13", if_rsp_data); end
      end
      @(negedge clk);
    end
    if_req_valid = 1'b0; ls_req_valid = 1'b0;
  endtask

  task automatic test_out_of_range();
    @(negedge clk);
    ls_req_valid = 1'b1; ls_req_we = 1'b0; ls_req_addr = 32'hFFFC;
    #1;
    n_assert++; if (ls_req_ready !== 1'b1 || mem_en !== 1'b1 || mem_addr !== 14'h3FFF) begin n_fail++; $display("FAIL last_word got rdy=%b en=%b addr=%h want 1 1 3fff", ls_req_ready, mem_en, mem_addr); end
    @(negedge clk);
    ls_req_addr = 32'h10000; ls_req_we = 1'b1; ls_req_be = 4'hF;
    #1;
    n_assert++; if (ls_req_ready !== 1'b1 || mem_en !== 1'b0 || mem_we !== 4'h0) begin n_fail++; $display("FAIL oor_drive got rdy=%b en=%b we=%h want 1 0 0", ls_req_ready, mem_en, mem_we); end
    n_assert++; if (ls_rsp_valid !== 1'b1 || ls_rsp_err !== 1'b0 || ls_rsp_data !== 32'hCAFEF00D) begin
      n_fail++; $display("FAIL last_rsp got vld=%b err=%b data=%h want 1 0 cafef00d", ls_rsp_valid, ls_rsp_err, ls_rsp_data);
    end
    @(negedge clk);
    ls_req_valid = 1'b0; ls_req_we = 1'b0; ls_req_be = 4'h0;
    #1;
    n_assert++; if (ls_rsp_valid !== 1'b1 || ls_rsp_err !== 1'b1 || ls_rsp_data !== 32'h0) begin
      n_fail++; $display("FAIL oor_rsp got vld=%b err=%b data=%h want 1 1 0", ls_rsp_valid, ls_rsp_err, ls_rsp_data);
    end
    @(negedge clk);
    #1;
    n_assert++; if (ls_rsp_valid !== 1'b0 || ls_rsp_err !== 1'b0) begin n_fail++; $display("FAIL oor_pulse got vld=%b err=%b want 0 0", ls_rsp_valid, ls_rsp_err); end
  endtask

  task automatic test_reset_mid_flight();
    @(negedge clk);
    if_req_valid = 1'b1; if_req_addr = 32'h8;
    #1;
    n_assert++; if (if_req_ready !== 1'b1) begin n_fail++; $display("FAIL mid_if_accept got %b want 1", if_req_ready); end
    @(negedge clk);
    if_req_valid = 1'b0; rst = 1'b1;
    ls_req_valid = 1'b1; ls_req_addr = 32'h100; ls_req_we = 1'b1; ls_req_be = 4'hF; ls_req_wdata = 32'hFFFFFFFF;
    #1;
    n_assert++; if (if_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rsp_drop got %b want 0", if_rsp_valid); end
    n_assert++; if (mem_we !== 4'h0 || mem_en !== 1'b0) begin n_fail++; $display("FAIL mid_store_block got we=%h en=%b want 0 0", mem_we, mem_en); end
    @(negedge clk);
    rst = 1'b0; ls_req_valid = 1'b0; ls_req_we = 1'b0; ls_req_be = 4'h0;
    #1;
    n_assert++; if (if_rsp_valid !== 1'b0 || ls_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL post_rst_rsp got if=%b ls=%b want 0 0", if_rsp_valid, ls_rsp_valid); end
    n_assert++; if (mem[14'h40] !== 32'h1122CCDD) begin n_fail++; $display("FAIL mem_unchanged got %h want 1122ccdd", mem[14'h40]); end
  endtask

  initial begin
    preload(14'h0, 32'h13);
    preload(14'h1, 32'h93);
    preload(14'h2, 32'h113);
    preload(14'h40, 32'h11223344);
    preload(14'h3FFF, 32'hCAFEF00D);
    test_reset();
    test_if_only();
    test_store_load();
    test_starvation();
    test_out_of_range();
    test_reset_mid_flight();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
